// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester round-robin arbiter in front of a single-port 16K x 64 memory.
// Requester 0 is the writeback path, requester 1 the refill/load path. Each
// valid/ready command becomes one memory beat; a requester may hold its grant
// across beats with lock, bounded to LOCK_MAX beats while the other one waits.
// Read data returns one cycle after issue, tagged with the issuing requester.
//
// Ports:
//   clka, rsta                 clock, asynchronous active-high reset
//   reqN_valid/ready           command handshake (N = 0, 1)
//   reqN_we/lock/addr/wdata    command: 1 = write, hold grant, address, data
//   rsp_valid/id/data          read response, id = issuing requester
//   mem_ena/wea/addra/dina     memory controls (mem_wea: 1 = read, 0 = write)
//   mem_douta                  memory read data, one cycle after read issue

module mem_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    // Counter value at which the next held cycle uses up the lock budget.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] LOCK_TOP  = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_t;

    state_t           state;
    logic             rr;
    logic [CNT_W-1:0] lock_cnt;
    logic             rd_pend;
    logic             rd_id;

    logic              sel;       // requester owning the current grant
    logic              granted;
    logic              cur_valid;
    logic              cur_we;
    logic              cur_lock;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              oth_valid;
    logic              pref_valid;
    logic              beat;
    state_t            oth_state;

    always_comb begin
        sel        = (state == StGnt1);
        granted    = (state != StIdle);
        cur_valid  = sel ? req1_valid : req0_valid;
        cur_we     = sel ? req1_we    : req0_we;
        cur_lock   = sel ? req1_lock  : req0_lock;
        cur_addr   = sel ? req1_addr  : req0_addr;
        cur_wdata  = sel ? req1_wdata : req0_wdata;
        oth_valid  = sel ? req0_valid : req1_valid;
        oth_state  = sel ? StGnt0 : StGnt1;
        pref_valid = rr ? req1_valid : req0_valid;
        beat       = granted & cur_valid;

        req0_ready = (state == StGnt0);
        req1_ready = (state == StGnt1);

        mem_ena   = beat;
        mem_wea   = beat ? ~cur_we : 1'b1;
        mem_addra = beat ? cur_addr : '0;
        mem_dina  = beat ? cur_wdata : '0;

        rsp_valid = rd_pend;
        rsp_id    = rd_id;
        rsp_data  = rd_pend ? mem_douta : '0;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state    <= StIdle;
            rr       <= 1'b0;
            lock_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            rd_pend <= beat & ~cur_we;
            if (beat && !cur_we) begin
                rd_id <= sel;
            end

            unique case (state)
                StIdle: begin
                    lock_cnt <= '0;
                    if (pref_valid) begin
                        state <= rr ? StGnt1 : StGnt0;
                    end else if (rr ? req0_valid : req1_valid) begin
                        state <= rr ? StGnt0 : StGnt1;
                    end
                end
                StGnt0, StGnt1: begin
                    if (beat && !cur_lock) begin
                        rr       <= ~sel;
                        state    <= oth_valid ? oth_state : StIdle;
                        lock_cnt <= '0;
                    end else if (cur_lock) begin
                        // Held cycles count against the budget whether or not
                        // a beat happened; release only if the other side waits.
                        if (lock_cnt >= LOCK_LAST && oth_valid) begin
                            rr       <= ~sel;
                            state    <= oth_state;
                            lock_cnt <= '0;
                        end else if (lock_cnt != LOCK_TOP) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        state    <= StIdle;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural 16K x 64 memory attached
// (one-cycle read latency). Inputs change 1 time unit after the rising edge;
// outputs are checked 1 time unit after that.

module tb_mem_arbiter;

    logic        clka = 1'b0;
    logic        rsta;
    logic        req0_valid, req0_ready, req0_we, req0_lock;
    logic [13:0] req0_addr;
    logic [63:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_we, req1_lock;
    logic [13:0] req1_addr;
    logic [63:0] req1_wdata;
    logic        rsp_valid, rsp_id;
    logic [63:0] rsp_data;
    logic        mem_ena, mem_wea;
    logic [13:0] mem_addra;
    logic [63:0] mem_dina;
    logic [63:0] mem_douta = '0;

    logic [63:0] mem_model [0:16383];

    int n_chk = 0;
    int n_err = 0;

    localparam logic [63:0] DEAD = 64'hDEADBEEF_00000001;
    localparam logic [63:0] PAT  = 64'h0BADF00D_00000100;

    always #5 clka = ~clka;

    mem_arbiter dut (
        .clka       (clka),
        .rsta       (rsta),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_lock  (req0_lock),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_lock  (req1_lock),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .mem_ena    (mem_ena),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_douta  (mem_douta)
    );

    // Memory: mem_wea = 0 writes, mem_wea = 1 reads with data next cycle.
    always @(posedge clka) begin
        if (mem_ena) begin
            if (!mem_wea) mem_model[mem_addra] <= mem_dina;
            else          mem_douta <= mem_model[mem_addra];
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsta = 1'b1;
        req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
        repeat (2) tick();

        // Reset values
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_ena", mem_ena, 0);
        chk("rst_wea", mem_wea, 1);
        chk("rst_addra", mem_addra, 0);
        chk("rst_dina", mem_dina, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);

        // Asynchronous reset in the middle of a granted cycle
        rsta = 1'b0;
        req0_valid = 1; req0_we = 0; req0_addr = 14'h0005;
        tick(); #1;
        chk("pre_rst_ena", mem_ena, 1);
        #2 rsta = 1'b1;
        #1;
        chk("async_rst_ena", mem_ena, 0);
        chk("async_rst_wea", mem_wea, 1);
        chk("async_rst_ready0", req0_ready, 0);
        tick();
        rsta = 1'b0;
        #1;
        chk("idle_no_ready", req0_ready, 0);

        // Read 0x0005 after reset
        tick(); #1;
        chk("rd5_ready0", req0_ready, 1);
        chk("rd5_ena", mem_ena, 1);
        chk("rd5_wea", mem_wea, 1);
        chk("rd5_addr", mem_addra, 14'h0005);
        tick();
        req0_valid = 0;
        #1;
        chk("rd5_rsp_valid", rsp_valid, 1);
        chk("rd5_rsp_id", rsp_id, 0);
        chk("rd5_rsp_data", rsp_data, 0);
        chk("rd5_idle", req0_ready, 0);

        // Requester 1 write then read of 0x3FFF
        req1_valid = 1; req1_we = 1; req1_addr = 14'h3FFF; req1_wdata = DEAD;
        tick(); #1;
        chk("wr_ready1", req1_ready, 1);
        chk("wr_ena", mem_ena, 1);
        chk("wr_wea", mem_wea, 0);
        chk("wr_addr", mem_addra, 14'h3FFF);
        chk("wr_dina", mem_dina, DEAD);
        tick();
        req1_we = 0;
        #1;
        chk("wr_bubble", req1_ready, 0);
        chk("wr_no_rsp", rsp_valid, 0);
        tick(); #1;
        chk("rd_ready1", req1_ready, 1);
        chk("rd_wea", mem_wea, 1);
        chk("rd_addr", mem_addra, 14'h3FFF);
        tick();
        req1_valid = 0;
        #1;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_id", rsp_id, 1);
        chk("rd_rsp_data", rsp_data, DEAD);
        tick(); #1;
        chk("rsp_gone_valid", rsp_valid, 0);
        chk("rsp_gone_data", rsp_data, 0);

        // Lock bound: req0 locked writes 0x0100.., req1 waiting from beat 2
        req0_valid = 1; req0_we = 1; req0_lock = 1; req0_addr = 14'h0100; req0_wdata = PAT;
        #1;
        chk("lk_idle", req0_ready, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            req0_addr  = 14'h0100 + 14'(k);
            req0_wdata = PAT + 64'(k);
            if (k == 1) begin
                req1_valid = 1; req1_we = 1; req1_lock = 0;
                req1_addr = 14'h0200; req1_wdata = 64'h22222222_33333333;
            end
            #1;
            chk("lk_ready0", req0_ready, 1);
            chk("lk_ready1", req1_ready, 0);
            chk("lk_addr", mem_addra, 14'h0100 + 14'(k));
            tick();
        end
        req0_addr = 14'h0108; req0_wdata = PAT + 64'd8;
        #1;
        chk("lk_rel_ready1", req1_ready, 1);
        chk("lk_rel_ready0", req0_ready, 0);
        chk("lk_rel_addr", mem_addra, 14'h0200);
        chk("lk_rel_wea", mem_wea, 0);
        tick();
        req1_valid = 0;
        for (int k = 8; k < 16; k++) begin
            req0_addr  = 14'h0100 + 14'(k);
            req0_wdata = PAT + 64'(k);
            req0_lock  = (k != 15);
            #1;
            chk("lk_tail_ready0", req0_ready, 1);
            chk("lk_tail_addr", mem_addra, 14'h0100 + 14'(k));
            tick();
        end
        req0_valid = 0; req0_lock = 0;
        #1;
        chk("lk_end_idle", req0_ready, 0);

        // Lock without contention: 12 contiguous beats
        req0_valid = 1; req0_we = 1; req0_lock = 1; req0_addr = 14'h0300; req0_wdata = '0;
        tick();
        for (int k = 0; k < 12; k++) begin
            req0_addr = 14'h0300 + 14'(k);
            req0_lock = (k != 11);
            #1;
            chk("nc_ready0", req0_ready, 1);
            chk("nc_ena", mem_ena, 1);
            tick();
        end
        req0_valid = 0; req0_lock = 0;
        #1;
        chk("nc_end_idle", req0_ready, 0);

        // Contention from reset: both read continuously
        rsta = 1'b1;
        req0_valid = 1; req0_we = 0; req0_addr = 14'h0100;
        req1_valid = 1; req1_we = 0; req1_addr = 14'h3FFF;
        tick();
        rsta = 1'b0;
        #1;
        chk("ct_idle0", req0_ready, 0);
        chk("ct_idle1", req1_ready, 0);
        for (int i = 1; i <= 6; i++) begin
            tick(); #1;
            chk("ct_ready0", req0_ready, (i % 2) == 1);
            chk("ct_ready1", req1_ready, (i % 2) == 0);
            chk("ct_addr", mem_addra, ((i % 2) == 1) ? 14'h0100 : 14'h3FFF);
            if (i >= 2) begin
                chk("ct_rsp_valid", rsp_valid, 1);
                chk("ct_rsp_id", rsp_id, (i % 2) == 1);
                chk("ct_rsp_data", rsp_data, ((i % 2) == 1) ? DEAD : PAT);
            end
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("ct_last_valid", rsp_valid, 1);
        chk("ct_last_id", rsp_id, 1);
        chk("ct_last_data", rsp_data, DEAD);
        tick(); #1;
        chk("ct_drain_ready0", req0_ready, 0);
        chk("ct_drain_rsp", rsp_valid, 0);

        // Reset with a read outstanding drops the response
        req0_valid = 1; req0_we = 0; req0_addr = 14'h0101;
        tick(); #1;
        chk("rr_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        #1;
        chk("rr_issued", rsp_valid, 1);
        rsta = 1'b1;
        #1;
        chk("rr_dropped", rsp_valid, 0);
        chk("rr_dropped_data", rsp_data, 0);
        tick();
        rsta = 1'b0;
        #1;
        chk("rr_after1", rsp_valid, 0);
        tick(); #1;
        chk("rr_after2", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
